// File: rtl/if_id_stage.sv
// Purpose : instruction-fetch stage owning the PC, plus the IF/ID pipeline register.
// Latency : 1 cycle; the word read at PC in cycle n is on IF_instruction in cycle n+1.
// Backpress: IF_stall freezes PC, IF/ID and the counter; imem not ready inserts a NOP bubble.
//
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   IF_stall          - hold everything (load-use hazard); also drops IF_imem_req
//   IF_flush/target   - taken branch/jump in ID; redirect PC, squash IF/ID
//   IF_imem_ready     - instruction memory serves the fetch this cycle
//   IF_imem_data      - combinational read data at IF_imem_addr
//   IF_imem_addr      - registered PC
//   IF_imem_req       - fetch request (= !IF_stall)
//   IF_instruction    - IF/ID instruction register
//   IF_pc_plus1       - IF/ID PC+1 register
//   IF_valid          - IF_instruction holds a real fetched word
//   IF_fetch_count    - saturating count of valid words delivered to ID
module if_id_stage #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        IF_stall,
  input  logic        IF_flush,
  input  logic [15:0] IF_target,
  input  logic        IF_imem_ready,
  input  logic [15:0] IF_imem_data,
  output logic [15:0] IF_imem_addr,
  output logic        IF_imem_req,
  output logic [15:0] IF_instruction,
  output logic [15:0] IF_pc_plus1,
  output logic        IF_valid,
  output logic [15:0] IF_fetch_count
);

  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] pc_plus1_q, pc_plus1_d;
  logic        valid_q, valid_d;
  logic [15:0] count_q, count_d;
  logic [15:0] pc_inc;

  // Wraps modulo 2^16 by width truncation.
  assign pc_inc = pc_q + 16'd1;

  // Priority: stall > flush > not-ready > normal (reset handled in the register block).
  // Flush is ignored while stalled: the branch in ID is itself frozen and will
  // re-assert flush once the stall releases.
  always_comb begin
    pc_d       = pc_q;
    instr_d    = instr_q;
    pc_plus1_d = pc_plus1_q;
    valid_d    = valid_q;
    count_d    = count_q;
    if (IF_stall) begin
      // hold all state
    end else if (IF_flush) begin
      // Wrong-path word is discarded even if memory was ready.
      pc_d    = IF_target;
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (!IF_imem_ready) begin
      // Shared-RAM conflict: refetch the same PC next cycle.
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else begin
      pc_d       = pc_inc;
      instr_d    = IF_imem_data;
      pc_plus1_d = pc_inc;
      valid_d    = 1'b1;
      if (count_q != 16'hFFFF) begin
        count_d = count_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      instr_q    <= NOP_INSTR;
      pc_plus1_q <= 16'h0000;
      valid_q    <= 1'b0;
      count_q    <= 16'h0000;
    end else begin
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      pc_plus1_q <= pc_plus1_d;
      valid_q    <= valid_d;
      count_q    <= count_d;
    end
  end

  assign IF_imem_addr   = pc_q;
  assign IF_imem_req    = !IF_stall;
  assign IF_instruction = instr_q;
  assign IF_pc_plus1    = pc_plus1_q;
  assign IF_valid       = valid_q;
  assign IF_fetch_count = count_q;

endmodule

// File: doc/if_id_stage.md
# if_id_stage

Instruction-fetch stage with the IF/ID pipeline register for the 16-bit five-stage pipeline. It owns the PC and drives the instruction-memory address. It latches the fetched instruction and PC+1 for decode. It obeys the stall from hazard detection and the redirect from branch resolution in ID, and inserts NOP bubbles when instruction memory is unavailable (shared-RAM structural hazard). Sits between instruction memory and the decode/hazard-detection logic.

## Interface
- RESET_PC, 16'h0000, PC value loaded on reset
- NOP_INSTR, 16'h0800, instruction word loaded into IF/ID on bubble/flush/reset
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- IF_stall  in  1  1 = hold PC and IF/ID (load-use hazard)
- IF_flush  in  1  1 = branch/jump taken in ID; redirect PC
- IF_target  in  16  redirect address, valid when IF_flush=1
- IF_imem_ready  in  1  1 = instruction memory serves fetch this cycle
- IF_imem_data  in  16  instruction word at IF_imem_addr, combinational read, valid when IF_imem_ready=1
- IF_imem_addr  out  16  current PC (registered)
- IF_imem_req  out  1  fetch request, = !IF_stall (only combinational output)
- IF_instruction  out  16  IF/ID instruction register
- IF_pc_plus1  out  16  IF/ID PC+1 register
- IF_valid  out  1  1 = IF_instruction is a real fetched instruction
- IF_fetch_count  out  16  count of valid instructions delivered to ID, saturating

## Operation
- Per-cycle priority, evaluated at the rising edge: rst > stall > flush > not-ready > normal.
- rst: PC←RESET_PC, IF_instruction←NOP_INSTR, IF_pc_plus1←16'h0000, IF_valid←0, IF_fetch_count←0.
- stall (IF_stall=1): PC, IF/ID and counter all hold. IF_flush is ignored. The branch in ID is itself stalled, so its outcome is not yet valid. The branch unit re-asserts IF_flush after the stall.
- flush (IF_stall=0, IF_flush=1): PC←IF_target, IF_instruction←NOP_INSTR, IF_valid←0, IF_pc_plus1 holds. This applies regardless of IF_imem_ready, and the wrong-path word is discarded.
- not-ready (IF_imem_ready=0): PC holds. IF/ID loads a bubble: IF_instruction←NOP_INSTR, IF_valid←0.
- normal: IF_instruction←IF_imem_data, IF_pc_plus1←PC+1, PC←PC+1, IF_valid←1, IF_fetch_count←count+1.
- Arithmetic: PC+1 is modulo 2^16 (16'hFFFF → 16'h0000, no flag). IF_fetch_count saturates at 16'hFFFF.
- No FSM beyond the PC/IF-ID registers. The stage has one implicit mode per cycle, as selected by the priority above.

## Timing
- Fetch-to-decode latency: 1 cycle. The word read at PC in cycle n appears on IF_instruction in cycle n+1.
- Redirect penalty: 1 bubble. Flush in cycle n gives IF_valid=0 in n+1 and the target instruction in n+2 (if ready).
- Stall has zero-cycle effect. All outputs in the cycle after a stalled edge equal the previous cycle's values.
- IF_imem_addr changes only at clock edges. IF_imem_req follows IF_stall combinationally.
- Reset mid-operation: next edge yields the reset values regardless of stall/flush/ready. First valid fetch is at RESET_PC on the first non-reset edge with ready=1.
- Stall held N cycles: IF/ID is unchanged for N cycles and the same PC is refetched after release. There is no duplicate delivery, and the count increments once.

## Test plan
- Reset then 4 cycles ready=1, imem_data=16'h1000+addr → IF_instruction 1000,1001,1002,1003; IF_pc_plus1 1,2,3,4; IF_fetch_count=4.
- PC=0x0005, IF_stall=1 for 3 cycles with IF_flush=1, IF_target=0x0040 → PC stays 0x0005 and IF/ID is unchanged. Flush re-asserted after release → PC=0x0040, one NOP bubble (IF_valid=0), then the instruction at 0x0040.
- PC=0x0010, ready=0 for 2 cycles → two bubbles (IF_instruction=0x0800, IF_valid=0), PC stays 0x0010, count unchanged. Ready=1 → word at 0x0010 delivered with IF_pc_plus1=0x0011.
- Flush with ready=0, target 0x0100 → PC=0x0100 next cycle, IF_valid=0.
- PC=0xFFFF, ready=1 → IF_pc_plus1=0x0000, PC=0x0000. Count preset near 0xFFFF saturates at 0xFFFF.
- rst asserted during stall+flush at PC=0x0033 → next edge PC=RESET_PC, IF_instruction=NOP_INSTR, IF_valid=0, count=0.
